// File: rtl/pwm.sv
`default_nettype none
// ============================================================================
// Module   : pwm
// Purpose  : Fixed-period PWM generator with synchronised duty input and
//            optional period-boundary duty load (macro PWM_SYNC_LOAD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pwm #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Input,
    output logic             OUT
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;
    logic             tick;
    logic             period_end;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Input;
            sync2 <= sync1;
        end
    end

    generate
        if (PRESCALE > 1) begin : g_pre
            logic [PRE_W-1:0] pre;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    pre <= '0;
                end else if (pre == PRE_W'(PRESCALE - 1)) begin
                    pre <= '0;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
            assign tick = (pre == PRE_W'(PRESCALE - 1));
        end else begin : g_nopre
            assign tick = 1'b1;
        end
    endgenerate

    assign period_end = tick && (cnt == {WIDTH{1'b1}});

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PWM_SYNC_LOAD_EN
    // Shadow load only as the counter wraps, so a period is never cut short.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            duty <= '0;
        end else if (period_end) begin
            duty <= sync2;
        end
    end
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            duty <= '0;
        end else begin
            duty <= sync2;
        end
    end
    logic unused_period_end;
    assign unused_period_end = period_end;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT <= 1'b0;
        end else begin
            OUT <= (cnt < duty);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm
// Purpose  : Scoreboard bench for pwm (PRESCALE 1 and 3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm;

`ifdef PWM_SYNC_LOAD_EN
    localparam bit SYNC_LOAD = 1'b1;
`else
    localparam bit SYNC_LOAD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] Input = 4'd0;
    logic       out1;
    logic       out3;

    pwm #(.WIDTH(4), .PRESCALE(1)) u_p1 (.CLK(CLK), .RST(RST), .Input(Input), .OUT(out1));
    pwm #(.WIDTH(4), .PRESCALE(3)) u_p3 (.CLK(CLK), .RST(RST), .Input(Input), .OUT(out3));

    always #20 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int hist [0:16383];

    typedef struct {
        logic e1;
        logic e3;
    } exp_t;
    exp_t q[$];
    exp_t e;

    // Input value seen at rising edge number k (k<=0 means before release).
    function automatic int inp_at(int k);
        return (k >= 1) ? hist[k] : 0;
    endfunction

    // Duty in force after edge m.
    function automatic int duty_after(int m, int p);
        int per;
        int last;
        if (SYNC_LOAD) begin
            per  = 16 * p;
            last = (m / per) * per;
            return (last == 0) ? 0 : inp_at(last - 2);
        end
        return inp_at(m - 2);
    endfunction

    // Output after edge k: counter position after edge k-1 against duty.
    function automatic logic exp_out(int k, int p);
        int m;
        int c;
        m = k - 1;
        c = (m / p) % 16;
        return logic'(c < duty_after(m, p));
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, n, act, req);
        end
    endtask

    always @(posedge CLK) begin
        if (!RST) begin
            n = 0;
        end else if (n < 16383) begin
            n = n + 1;
            hist[n] = int'(Input);
            q.push_back('{exp_out(n, 1), exp_out(n, 3)});
        end
    end

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check("out_p1", out1, e.e1);
            check("out_p3", out3, e.e3);
        end else if (!RST) begin
            check("reset_p1", out1, 1'b0);
            check("reset_p3", out3, 1'b0);
        end
    end

    task automatic set_in(input logic [3:0] v);
        @(negedge CLK);
        #2 Input = v;
    endtask

    task automatic run(input int k);
        repeat (k) @(negedge CLK);
    endtask

    initial begin
        RST   = 1'b0;
        Input = 4'd8;
        #100;
        check("hold_p1", out1, 1'b0);
        check("hold_p3", out3, 1'b0);
        @(negedge CLK);
        #5 RST = 1'b1;

        run(200);
        set_in(4'd0);
        run(170);
        set_in(4'd15);
        run(160);
        set_in(4'd8);
        run(100);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            if (n % 16 == 5) break;
        end
        set_in(4'd4);
        run(100);

        // Asynchronous reset mid-waveform while the output is high.
        set_in(4'd15);
        run(60);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (out1 && out3) break;
        end
        #5 RST = 1'b0;
        #1;
        check("async_p1", out1, 1'b0);
        check("async_p3", out3, 1'b0);
        run(3);
        #5 RST = 1'b1;

        for (int s = 0; s < 40; s++) begin
            set_in(4'($urandom_range(0, 15)));
            run(int'($urandom_range(1, 60)));
        end
        run(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pwm.md
# pwm

Pulse-width modulator for motor drive: converts an unsigned duty code on `Input` into a fixed-period PWM waveform on `OUT`. The block sits between a control/switch source and the motor driver pin. `Input` may be asynchronous to `CLK`, so the block resynchronises it internally. The duty value is applied glitch-free at period boundaries.

## Interface
- `WIDTH`, default 4: duty-code width. The PWM period is 2^WIDTH ticks.
- `PRESCALE`, default 1: `CLK` cycles per PWM tick. Legal range ≥1; 1 means one tick every cycle.
- `CLK`  input  1  clock, rising-edge active.
- `RST`  input  1  reset. One clock; reset is asynchronous and active-low.
- `Input`  input  WIDTH  unsigned duty code. Asynchronous to `CLK`.
- `OUT`  output  1  registered PWM output, active-high.

## Operation
- Input synchroniser:
  - two flops, `sync1 <= Input` and `sync2 <= sync1`, clocked every cycle.
- Prescaler:
  - `pre` counts 0..PRESCALE-1 and wraps to 0.
  - `tick` = (`pre` == PRESCALE-1).
  - With PRESCALE=1, `tick` is constantly 1.
- Period counter:
  - `cnt` is WIDTH bits.
  - On `tick`: `cnt <= cnt+1`, wrapping from 2^WIDTH-1 to 0.
- Duty shadow register `duty` (WIDTH bits):
  - loaded from `sync2` when `tick` and `cnt` == 2^WIDTH-1 (period end), unless the configuration macro is undefined (see Configuration).
  - A new duty takes effect from `cnt` = 0.
- Output:
  - `OUT <= (cnt < duty)` every `CLK` cycle.
  - The comparison is unsigned, WIDTH bits.
- Arithmetic and boundary rules:
  - duty 0 → `OUT` constantly 0.
  - duty 2^WIDTH-1 → high for 2^WIDTH-1 of 2^WIDTH ticks. 100% duty is not reachable.
  - duty 2^(WIDTH-1) (8 for WIDTH=4) → exactly 50%.
  - Mid-period changes of `Input` do not affect the current period.
  - No overflow paths exist; all counters wrap modulo their range.
- Reset (`RST` low, asynchronous):
  - `sync1`, `sync2`, `duty`, `cnt`, `pre` all = 0.
  - `OUT` = 0 immediately, regardless of `CLK`.
  - Reset asserted mid-period aborts the period. After release, the block restarts at `cnt` = 0 with duty 0 until the next load.

## Timing
- Edges are counted from the first rising `CLK` edge with `RST` high (edge 1).
- With PRESCALE=1, WIDTH=4, `Input` stable at 8 from reset:
  - `sync2` = 8 after edge 2.
  - `cnt` reaches 15 after edge 15.
  - `duty` is loaded at edge 16, as `cnt` wraps to 0.
  - `OUT` rises at edge 17 and falls at edge 25.
  - The waveform then repeats every 16 cycles: 8 high, 8 low.
- Latency from `Input` change to `OUT` effect:
  - 2 cycles for synchronisation, plus the wait to the next period boundary, plus 1 cycle for the output register.
- With PRESCALE=P:
  - every tick lasts P cycles, so the period is P·2^WIDTH cycles.
  - `OUT` edges stay aligned to `CLK` edges, one cycle after the `cnt` change.

## Configuration
- `PWM_SYNC_LOAD_EN`:
  - Defined: `duty` loads only at the period boundary, as described above. This is glitch-free.
  - Undefined: `duty <= sync2` every `CLK` cycle. A duty change takes effect on the first comparison after it reaches `duty`, so a period may contain a truncated or extended pulse.
  - All other behaviour is identical in both cases.

## Test plan
- Reset hold: `RST` = 0 for 100 ns with `Input` = 8 → `OUT` = 0. Assert mid-waveform → `OUT` drops to 0 asynchronously, before the next `CLK` edge.
- 50% duty (WIDTH=4, PRESCALE=1, macro defined, 40 ns `CLK`): `Input` = 8, then release reset → first `OUT` rise at edge 17; waveform 8 cycles high / 8 low, period 640 ns.
- Extremes: `Input` = 0 → `OUT` never high over 3 periods. `Input` = 15 → 15 high / 1 low per period.
- Mid-period change (macro defined): switch `Input` 8→4 while `cnt` = 5 → the current period stays 8 high; the next period is 4 high / 12 low.
- Macro undefined: same 8→4 switch at `cnt` = 5 → `OUT` falls within 3 cycles, with no wait for the boundary.
- Prescale: PRESCALE=3, `Input` = 8 → period 48 cycles, 24 high / 24 low.
